// File: rtl/upstream_port_sink.sv
// -----------------------------------------------------------------------------
// upstream_port_sink
//
// Consumer sitting at the far end of one switch output port. It waits for the
// switch to flag a pending packet, requests it with a one-cycle data_rd pulse,
// and captures the payload bytes that follow. Bytes are buffered in a FIFO
// together with the packet address and a last-byte tag. They are then replayed
// to local logic over a valid/ready byte stream. Packet and error statistics are
// kept alongside.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : asynchronous, active-high reset; release must already be
//                synchronous to clk (it is synchronised upstream)
//   addr_out   : packet address from the switch, valid while valid_out=1
//   data_out   : payload byte from the switch
//   valid_out  : switch has a packet pending / current byte is valid
//   data_rd    : one-cycle read request to the switch
//   out_data   : FIFO head payload byte (0 when empty)
//   out_addr   : FIFO head packet address (0 when empty)
//   out_last   : FIFO head is the last byte of its packet (0 when empty)
//   out_valid  : FIFO non-empty
//   out_ready  : local consumer takes the head this cycle
//   pkt_count  : packets fully written into the FIFO, wraps
//   len_err    : sticky, a packet exceeded MAX_PKT bytes
//   empty_err  : one-cycle pulse, a zero-length packet was seen
// -----------------------------------------------------------------------------
module upstream_port_sink #(
    parameter int DEPTH   = 32,   // FIFO entries, power of two, >= MAX_PKT
    parameter int MAX_PKT = 16,   // max accepted payload bytes per packet
    parameter int CNT_W   = 16    // width of pkt_count
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       addr_out,
    input  logic [7:0]       data_out,
    input  logic             valid_out,
    output logic             data_rd,
    output logic [7:0]       out_data,
    output logic [7:0]       out_addr,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_count,
    output logic             len_err,
    output logic             empty_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    state_t state;
    state_t state_nxt;

    // Packet capture context
    logic [7:0]    pkt_addr;
    logic [BW-1:0] byte_cnt;
    logic          byte_ok;
    logic          stage_valid;
    logic [7:0]    stage_data;

    // FIFO storage and pointers; the extra MSB is the wrap bit so that
    // wr_ptr - rd_ptr gives the occupancy directly, full included.
    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   free;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;

    assign count     = wr_ptr - rd_ptr;
    assign free      = (AW+1)'(DEPTH) - count;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign byte_ok   = (byte_cnt < BW'(MAX_PKT));

    // Head outputs are forced to zero while empty so that the stale contents
    // of the unreset storage never show up on the port.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = out_valid ? head.data : 8'h00;
    assign out_addr  = out_valid ? head.addr : 8'h00;
    assign out_last  = out_valid ? head.last : 1'b0;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state, read request and FIFO push decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        data_rd    = 1'b0;
        push       = 1'b0;
        push_entry = '0;

        case (state)
            IDLE: begin
                // Only start a packet when a worst-case packet is sure to fit.
                if (valid_out && (free >= (AW+1)'(MAX_PKT))) begin
                    state_nxt = REQ;
                end
            end

            REQ: begin
                data_rd   = 1'b1;
                state_nxt = RECV;
            end

            RECV: begin
                if (valid_out) begin
                    // A new accepted byte retires the previously staged one,
                    // which therefore cannot be the last of the packet.
                    if (byte_ok && stage_valid) begin
                        push       = 1'b1;
                        push_entry = '{last: 1'b0, addr: pkt_addr, data: stage_data};
                    end
                end else begin
                    // End of packet: whatever is staged is the final byte.
                    if (stage_valid) begin
                        push       = 1'b1;
                        push_entry = '{last: 1'b1, addr: pkt_addr, data: stage_data};
                    end
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture context, pointers and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_addr    <= 8'h00;
            byte_cnt    <= '0;
            stage_valid <= 1'b0;
            stage_data  <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pkt_count   <= '0;
            len_err     <= 1'b0;
            empty_err   <= 1'b0;
        end else begin
            empty_err <= 1'b0;

            if (state == REQ) begin
                pkt_addr    <= addr_out;
                byte_cnt    <= '0;
                stage_valid <= 1'b0;
            end

            if (state == RECV) begin
                if (valid_out) begin
                    if (byte_ok) begin
                        stage_data  <= data_out;
                        stage_valid <= 1'b1;
                        byte_cnt    <= byte_cnt + BW'(1);
                    end else begin
                        // Excess bytes are dropped; the counter saturates so
                        // arbitrarily long packets cannot wrap it.
                        len_err <= 1'b1;
                    end
                end else begin
                    stage_valid <= 1'b0;
                    if (stage_valid) begin
                        pkt_count <= pkt_count + CNT_W'(1);
                    end else begin
                        empty_err <= 1'b1;
                    end
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are meaningful, and resetting a RAM-style array would
    // prevent mapping it onto memory resources.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: tb/tb_upstream_port_sink.sv
// -----------------------------------------------------------------------------
// tb_upstream_port_sink
//
// Directed bench for upstream_port_sink. A switch-side driver task plays
// packets into the DUT and, from the packet contents alone, appends the FIFO
// entries they must produce to a scoreboard queue and updates the expected
// statistics. A negedge compare process checks every pop and the statistics
// each cycle. A few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_upstream_port_sink;

    localparam int DEPTH   = 32;
    localparam int MAX_PKT = 16;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       addr_out;
    logic [7:0]       data_out;
    logic             valid_out;
    logic             data_rd;
    logic [7:0]       out_data;
    logic [7:0]       out_addr;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] pkt_count;
    logic             len_err;
    logic             empty_err;

    always #5 clk = ~clk;

    upstream_port_sink #(
        .DEPTH   (DEPTH),
        .MAX_PKT (MAX_PKT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .data_rd   (data_rd),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .len_err   (len_err),
        .empty_err (empty_err)
    );

    typedef logic [7:0] byte_q_t [$];

    typedef struct packed {
        logic       last;
        logic [7:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t             exp_q [$];
    logic [CNT_W-1:0] exp_pkt_count = '0;
    logic             exp_len_err   = 1'b0;
    logic             exp_empty_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Compare process: statistics every cycle, head entry on every pop.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        check("pkt_count", 32'(pkt_count), 32'(exp_pkt_count));
        check("len_err", 32'(len_err), 32'(exp_len_err));
        check("empty_err", 32'(empty_err), 32'(exp_empty_err));
        if (!out_valid) begin
            check("empty_head_zero", {15'd0, out_last, out_addr, out_data}, 32'd0);
        end else if (out_ready) begin
            check("model_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("pop_entry", {15'd0, out_last, out_addr, out_data}, 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (!reset && dut.push) begin
            check("no_write_when_full", 32'(dut.count == DEPTH), 32'd0);
        end
    end

    // -------------------------------------------------------------------------
    // Switch-side driver. Inputs change 1 time unit after a rising edge.
    // -------------------------------------------------------------------------
    task automatic send_pkt(input logic [7:0] addr, input byte_q_t bytes, input int budget);
        int waited = 0;
        int n      = bytes.size();
        @(posedge clk); #1;
        valid_out = 1'b1;
        addr_out  = addr;
        data_out  = 8'hEE;
        do begin
            @(negedge clk);
            waited++;
        end while (!data_rd && waited < budget);
        check("data_rd_seen", 32'(data_rd), 32'd1);
        if (!data_rd) begin
            valid_out = 1'b0;
            return;
        end
        // Expected FIFO contents: first MAX_PKT bytes, last tag on the final
        // kept byte, all carrying the address presented at request time.
        for (int i = 0; i < n && i < MAX_PKT; i++) begin
            exp_q.push_back('{last: (i == n - 1) || (i == MAX_PKT - 1), addr: addr, data: bytes[i]});
        end
        @(posedge clk); #1;
        addr_out = 8'h00;   // the address must already be latched
        for (int i = 0; i < n; i++) begin
            data_out = bytes[i];
            @(negedge clk);
            check("data_rd_single_cycle", 32'(data_rd), 32'd0);
            @(posedge clk); #1;
            if (i >= MAX_PKT) exp_len_err = 1'b1;
        end
        valid_out = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            check("data_rd_single_cycle", 32'(data_rd), 32'd0);
        end
        @(posedge clk); #1;
        if (n > 0) exp_pkt_count = exp_pkt_count + 1'b1;
        else       exp_empty_err = 1'b1;
        @(posedge clk); #1;
        exp_empty_err = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        byte_q_t q;

        reset     = 1'b1;
        addr_out  = 8'h00;
        data_out  = 8'h00;
        valid_out = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_data_rd", 32'(data_rd), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_head", {15'd0, out_last, out_addr, out_data}, 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;

        // ---------------- single packet ----------------
        q = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h5A, q, 20);
        @(negedge clk);
        check("single_pkt_count", 32'(pkt_count), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("single_e0", {15'd0, out_last, out_addr, out_data}, {15'd0, 1'b0, 8'h5A, 8'h11});
        @(negedge clk);
        check("single_e1", {15'd0, out_last, out_addr, out_data}, {15'd0, 1'b0, 8'h5A, 8'h22});
        @(negedge clk);
        check("single_e2", {15'd0, out_last, out_addr, out_data}, {15'd0, 1'b1, 8'h5A, 8'h33});
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("single_drained", 32'(out_valid), 32'd0);

        // ---------------- oversize packet ----------------
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'h40 + 8'(i));
        send_pkt(8'hC3, q, 20);
        @(negedge clk);
        check("oversize_len_err", 32'(len_err), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("oversize_entry", {15'd0, out_last, out_addr, out_data},
                  {15'd0, 1'(i == 15), 8'hC3, 8'h40 + 8'(i)});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("oversize_16_only", 32'(out_valid), 32'd0);
        q = '{8'h01, 8'h02};
        send_pkt(8'h21, q, 20);
        drain(50);
        check("len_err_sticky", 32'(len_err), 32'd1);

        // ---------------- backpressure ----------------
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'h80 + 8'(i));
        send_pkt(8'hA1, q, 20);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'h90 + 8'(i));
        send_pkt(8'hA2, q, 20);
        @(negedge clk);
        check("bp_full", 32'(exp_pkt_count), 32'(pkt_count));
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'hB0 + 8'(i));
        fork
            send_pkt(8'hA3, q, 200);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_blocked", 32'(data_rd), 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                repeat (16) begin
                    @(negedge clk);
                    check("bp_blocked_while_popping", 32'(data_rd), 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
            end
        join

        // ---------------- streaming from full ----------------
        @(posedge clk); #1;
        out_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'hD0 + 8'(i));
        send_pkt(8'hA4, q, 200);
        drain(200);

        // ---------------- streaming through empty ----------------
        @(posedge clk); #1;
        out_ready = 1'b1;
        q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
        send_pkt(8'h3C, q, 20);
        drain(50);

        // ---------------- zero-length packet ----------------
        q.delete();
        send_pkt(8'h66, q, 20);
        @(negedge clk);
        check("zero_len_fifo_empty", 32'(out_valid), 32'd0);

        // ---------------- async reset mid-packet ----------------
        q = '{8'h55};
        send_pkt(8'h10, q, 20);   // leave one entry sitting in the FIFO
        @(posedge clk); #1;
        valid_out = 1'b1;
        addr_out  = 8'h77;
        begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!data_rd && w < 20);
            check("rst_test_req", 32'(data_rd), 32'd1);
        end
        @(posedge clk); #1; data_out = 8'hA1;
        @(posedge clk); #1; data_out = 8'hA2;
        @(posedge clk); #1; data_out = 8'hA3;
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_pkt_count = '0;
        exp_len_err   = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_pkt_count", 32'(pkt_count), 32'd0);
        check("async_rst_len_err", 32'(len_err), 32'd0);
        check("async_rst_head", {15'd0, out_last, out_addr, out_data}, 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        q = '{8'hB1, 8'hB2};
        send_pkt(8'h77, q, 20);
        @(negedge clk);
        check("post_rst_pkt_count", 32'(pkt_count), 32'd1);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/upstream_port_sink.md
Name: upstream_port_sink

Overview:
- Consumer at the far end of the switch's upstream (output-port) interface.
- Detects a pending packet on valid_out and requests it with data_rd. Captures the addr_out/data_out byte stream into an internal FIFO, tagging the final byte of each packet.
- Replays buffered bytes to local logic over a valid/ready byte stream, and keeps packet and error statistics.
- One instance per switch output port.

Parameters:
- DEPTH, 32, FIFO entries; power of two; must be >= MAX_PKT.
- MAX_PKT, 16, maximum accepted payload bytes per packet; also the free-space threshold for starting a read.
- CNT_W, 16, width of pkt_count.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- addr_out  input  8  packet address from switch; valid while valid_out=1.
- data_out  input  8  payload byte from switch.
- valid_out  input  1  switch has a packet pending / byte valid.
- data_rd  output  1  read request/acknowledge to switch.
- out_data  output  8  FIFO head payload byte.
- out_addr  output  8  FIFO head packet address.
- out_last  output  1  FIFO head is the last byte of its packet.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  local consumer accepts head this cycle.
- pkt_count  output  CNT_W  packets fully written into FIFO; wraps modulo 2^CNT_W.
- len_err  output  1  sticky: a packet exceeded MAX_PKT.
- empty_err  output  1  one-cycle pulse: zero-length packet seen.

Behaviour:
- Reset (async assert, sync deassert to posedge):
  - FSM goes to IDLE.
  - data_rd=0, FIFO empty, out_valid=0, out_data/out_addr/out_last=0.
  - pkt_count=0, len_err=0, empty_err=0, staging register empty.
- Reset mid-packet discards the partial packet and staged byte. If valid_out is still high afterwards, it is treated as a new packet.
- FSM states:
  - IDLE: data_rd=0. If valid_out=1 and free entries (DEPTH-count) >= MAX_PKT, go to REQ. Otherwise stay.
  - REQ: data_rd=1 for this one cycle only. Latch addr_out into the packet address register. Clear the byte counter. Go to RECV.
  - RECV: data_rd=0. Each cycle with valid_out=1 is one payload byte.
    - Byte index < MAX_PKT: byte enters the staging register. Any previously staged byte is pushed to the FIFO as {last=0, addr, data}.
    - Byte index >= MAX_PKT: byte is dropped and len_err is set (sticky until reset).
    - First cycle with valid_out=0 ends the packet: push the staged byte with last=1, increment pkt_count in the same cycle, then go to IDLE.
    - If no byte was staged, make no push, leave pkt_count unchanged, pulse empty_err for one cycle, then go to IDLE.
- Latency:
  - The first payload byte is sampled the cycle after REQ.
  - A byte reaches the FIFO one cycle after the next byte or end-of-packet is sampled.
  - out_valid rises the cycle after the first FIFO write.
- Overflow: the free-space gate guarantees a FIFO write never occurs when full. Writes while full are a design error (bench assertion).
- Output side:
  - out_* reflect the FIFO head combinationally from registered storage.
  - Pop when out_valid & out_ready.
  - out_ready while empty has no effect.
  - Simultaneous push and pop is legal at any occupancy, including empty→push and full→pop.
  - Read/write pointers are log2(DEPTH) bits plus a wrap bit; count = wr - rd.
- Back-to-back packets: IDLE→REQ requires at least one IDLE cycle, so the minimum gap between packets is 1 cycle after end-of-packet.

Test Plan:
- Single packet: valid_out=1 with addr_out=0x5A, bytes 0x11,0x22,0x33, then valid_out=0 → data_rd pulses exactly 1 cycle. FIFO yields (0x5A,0x11,last0), (0x5A,0x22,last0), (0x5A,0x33,last1). pkt_count=1.
- Oversize: 20-byte packet, MAX_PKT=16 → 16 entries written, 16th has last=1, len_err=1 and stays set. Next normal packet is still received correctly.
- Backpressure: out_ready=0, send two 16-byte packets with DEPTH=32 → both accepted. A third pending packet keeps data_rd=0 until the consumer pops 16 entries, then REQ occurs.
- Zero-length: REQ followed immediately by valid_out=0 → empty_err pulses 1 cycle, FIFO unchanged, pkt_count unchanged.
- Simultaneous push/pop at full and at empty with out_ready=1 streaming → no entry lost or duplicated; ordering matches the scoreboard.
- Async reset asserted mid-RECV between cycles → outputs clear immediately, out_valid=0, pkt_count=0. After release, a fresh packet is received correctly.
